// File: rtl/npu_inst_encoder.sv
// Packs one layer configuration into up to three 128-bit NPU instruction words
// (IOB2N, WB2N, N2IOB) and issues them in order over a valid/ready stream.
module npu_inst_encoder (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic [2:0]   cfg_mask_i,
  input  logic [11:0]  cfg_addr_d_i,
  input  logic [11:0]  cfg_addr_w_i,
  input  logic [11:0]  cfg_addr_s_i,
  input  logic [7:0]   cfg_addr_b_i,
  input  logic [1:0]   cfg_buffer_flag_i,
  input  logic [1:0]   cfg_tilingtype_i,
  input  logic [1:0]   cfg_stride_i,
  input  logic [1:0]   cfg_pad_i,
  input  logic [1:0]   cfg_xpe_mode_i,
  input  logic [3:0]   cfg_mode_i,
  input  logic [3:0]   cfg_last_part_i,
  input  logic [3:0]   cfg_kernel_i,
  input  logic [3:0]   cfg_w_q_i,
  input  logic [3:0]   cfg_i_q_i,
  input  logic [3:0]   cfg_o_q_i,
  input  logic [7:0]   cfg_in_x_i,
  input  logic [7:0]   cfg_in_y_i,
  input  logic [7:0]   cfg_in_piece_i,
  input  logic [7:0]   cfg_part_num_i,
  input  logic [7:0]   cfg_avg_coe_i,
  input  logic [7:0]   cfg_out_x_i,
  input  logic [7:0]   cfg_out_y_i,
  input  logic [7:0]   cfg_out_piece_i,
  input  logic [7:0]   cfg_jump_i,
  input  logic [7:0]   cfg_store_i,
  output logic [127:0] inst_out_o,
  output logic         inst_valid_o,
  input  logic         inst_ready_i,
  output logic         done_o,
  output logic [15:0]  inst_cnt_o
);

  localparam logic [4:0] OPC_IOB2N = 5'b01010;
  localparam logic [4:0] OPC_WB2N  = 5'b01011;
  localparam logic [4:0] OPC_N2IOB = 5'b01101;

  typedef enum logic [2:0] {IDLE, IOB, WB, NIO, FIN} state_t;

  typedef struct packed {
    logic [11:0] addr_d, addr_w, addr_s;
    logic [7:0]  addr_b;
    logic [1:0]  buffer_flag, tilingtype, stride, pad, xpe_mode;
    logic [3:0]  mode, last_part, kernel, w_q, i_q, o_q;
    logic [7:0]  in_x, in_y, in_piece, part_num, avg_coe;
    logic [7:0]  out_x, out_y, out_piece, jump, store;
  } fields_t;

  state_t        state_q, state_d;
  fields_t       fields_q, fields_d, fields_in;
  logic [2:0]    mask_q, mask_d;
  logic [127:0]  inst_out_q, word_d;
  logic          inst_valid_q, done_q;
  logic [15:0]   inst_cnt_q;
  logic          accept, xfer;

  assign accept = (state_q == IDLE) && cfg_valid_i;
  assign xfer   = inst_valid_q && inst_ready_i;

  always_comb begin
    fields_in = '{
      addr_d: cfg_addr_d_i, addr_w: cfg_addr_w_i, addr_s: cfg_addr_s_i,
      addr_b: cfg_addr_b_i, buffer_flag: cfg_buffer_flag_i,
      tilingtype: cfg_tilingtype_i, stride: cfg_stride_i, pad: cfg_pad_i,
      xpe_mode: cfg_xpe_mode_i, mode: cfg_mode_i, last_part: cfg_last_part_i,
      kernel: cfg_kernel_i, w_q: cfg_w_q_i, i_q: cfg_i_q_i, o_q: cfg_o_q_i,
      in_x: cfg_in_x_i, in_y: cfg_in_y_i, in_piece: cfg_in_piece_i,
      part_num: cfg_part_num_i, avg_coe: cfg_avg_coe_i, out_x: cfg_out_x_i,
      out_y: cfg_out_y_i, out_piece: cfg_out_piece_i, jump: cfg_jump_i,
      store: cfg_store_i
    };
    fields_d = accept ? fields_in : fields_q;
    mask_d   = accept ? cfg_mask_i : mask_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_valid_i) begin
        if (cfg_mask_i[0])      state_d = IOB;
        else if (cfg_mask_i[1]) state_d = WB;
        else if (cfg_mask_i[2]) state_d = NIO;
        else                    state_d = FIN;
      end
      IOB: if (xfer) begin
        if (mask_q[1])      state_d = WB;
        else if (mask_q[2]) state_d = NIO;
        else                state_d = FIN;
      end
      WB:  if (xfer) state_d = mask_q[2] ? NIO : FIN;
      NIO: if (xfer) state_d = FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    word_d = '0;
    case (state_d)
      IOB: word_d = {OPC_IOB2N, 1'b0, fields_d.addr_d, fields_d.buffer_flag,
                     fields_d.mode, fields_d.in_x, fields_d.in_y,
                     fields_d.in_piece, fields_d.tilingtype, fields_d.part_num,
                     fields_d.last_part, 8'b0, fields_d.avg_coe, 50'b0};
      WB:  word_d = {OPC_WB2N, 1'b0, fields_d.addr_w, 4'b0, fields_d.addr_b,
                     fields_d.kernel, fields_d.stride, fields_d.pad,
                     fields_d.w_q, fields_d.i_q, fields_d.o_q, 78'b0};
      NIO: word_d = {OPC_N2IOB, 1'b0, fields_d.addr_s, fields_d.out_x,
                     fields_d.out_y, fields_d.out_piece, fields_d.jump,
                     fields_d.store, 16'b0, fields_d.xpe_mode, 52'b0};
      default: word_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fields_q     <= '0;
      mask_q       <= '0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
      inst_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fields_q     <= fields_d;
      mask_q       <= mask_d;
      inst_out_q   <= word_d;
      inst_valid_q <= (state_d == IOB) || (state_d == WB) || (state_d == NIO);
      done_q       <= (state_d == FIN);
      if (xfer) inst_cnt_q <= inst_cnt_q + 16'd1;
    end
  end

  assign cfg_ready_o  = (state_q == IDLE);
  assign inst_out_o   = inst_out_q;
  assign inst_valid_o = inst_valid_q;
  assign done_o       = done_q;
  assign inst_cnt_o   = inst_cnt_q;

endmodule

// File: tb/tb_npu_inst_encoder.sv
// Directed bench for npu_inst_encoder: expected words are queued on config
// accept and popped by a monitor on every inst_valid/inst_ready handshake.
module tb_npu_inst_encoder;

  typedef struct {
    logic [11:0] addr_d, addr_w, addr_s;
    logic [7:0]  addr_b;
    logic [1:0]  buffer_flag, tilingtype, stride, pad, xpe_mode;
    logic [3:0]  mode, last_part, kernel, w_q, i_q, o_q;
    logic [7:0]  in_x, in_y, in_piece, part_num, avg_coe;
    logic [7:0]  out_x, out_y, out_piece, jump, store;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [2:0] cfg_mask = '0;
  logic [11:0] addr_d = '0, addr_w = '0, addr_s = '0;
  logic [7:0] addr_b = '0;
  logic [1:0] buffer_flag = '0, tilingtype = '0, stride = '0, pad = '0, xpe_mode = '0;
  logic [3:0] mode = '0, last_part = '0, kernel = '0, w_q = '0, i_q = '0, o_q = '0;
  logic [7:0] in_x = '0, in_y = '0, in_piece = '0, part_num = '0, avg_coe = '0;
  logic [7:0] out_x = '0, out_y = '0, out_piece = '0, jump = '0, store = '0;
  logic [127:0] inst_out;
  logic inst_valid;
  logic inst_ready = 1'b1;
  logic done;
  logic [15:0] inst_cnt;

  int checks = 0;
  int failures = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  npu_inst_encoder dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_mask_i(cfg_mask), .cfg_addr_d_i(addr_d), .cfg_addr_w_i(addr_w),
    .cfg_addr_s_i(addr_s), .cfg_addr_b_i(addr_b), .cfg_buffer_flag_i(buffer_flag),
    .cfg_tilingtype_i(tilingtype), .cfg_stride_i(stride), .cfg_pad_i(pad),
    .cfg_xpe_mode_i(xpe_mode), .cfg_mode_i(mode), .cfg_last_part_i(last_part),
    .cfg_kernel_i(kernel), .cfg_w_q_i(w_q), .cfg_i_q_i(i_q), .cfg_o_q_i(o_q),
    .cfg_in_x_i(in_x), .cfg_in_y_i(in_y), .cfg_in_piece_i(in_piece),
    .cfg_part_num_i(part_num), .cfg_avg_coe_i(avg_coe), .cfg_out_x_i(out_x),
    .cfg_out_y_i(out_y), .cfg_out_piece_i(out_piece), .cfg_jump_i(jump),
    .cfg_store_i(store), .inst_out_o(inst_out), .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready), .done_o(done), .inst_cnt_o(inst_cnt)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] expWord(input int kind, input cfg_t c);
    logic [127:0] w;
    w = '0;
    if (kind == 0) begin
      w[127:123] = 5'b01010; w[121:110] = c.addr_d; w[109:108] = c.buffer_flag;
      w[107:104] = c.mode;   w[103:96] = c.in_x;     w[95:88] = c.in_y;
      w[87:80] = c.in_piece; w[79:78] = c.tilingtype; w[77:70] = c.part_num;
      w[69:66] = c.last_part; w[57:50] = c.avg_coe;
    end else if (kind == 1) begin
      w[127:123] = 5'b01011; w[121:110] = c.addr_w; w[105:98] = c.addr_b;
      w[97:94] = c.kernel;   w[93:92] = c.stride;   w[91:90] = c.pad;
      w[89:86] = c.w_q;      w[85:82] = c.i_q;      w[81:78] = c.o_q;
    end else begin
      w[127:123] = 5'b01101; w[121:110] = c.addr_s; w[109:102] = c.out_x;
      w[101:94] = c.out_y;   w[93:86] = c.out_piece; w[85:78] = c.jump;
      w[77:70] = c.store;    w[53:52] = c.xpe_mode;
    end
    return w;
  endfunction

  function automatic cfg_t randCfg();
    cfg_t c;
    c.addr_d = 12'($urandom); c.addr_w = 12'($urandom); c.addr_s = 12'($urandom);
    c.addr_b = 8'($urandom); c.buffer_flag = 2'($urandom); c.tilingtype = 2'($urandom);
    c.stride = 2'($urandom); c.pad = 2'($urandom); c.xpe_mode = 2'($urandom);
    c.mode = 4'($urandom); c.last_part = 4'($urandom); c.kernel = 4'($urandom);
    c.w_q = 4'($urandom); c.i_q = 4'($urandom); c.o_q = 4'($urandom);
    c.in_x = 8'($urandom); c.in_y = 8'($urandom); c.in_piece = 8'($urandom);
    c.part_num = 8'($urandom); c.avg_coe = 8'($urandom); c.out_x = 8'($urandom);
    c.out_y = 8'($urandom); c.out_piece = 8'($urandom); c.jump = 8'($urandom);
    c.store = 8'($urandom);
    return c;
  endfunction

  task automatic driveFields(input cfg_t c);
    addr_d = c.addr_d; addr_w = c.addr_w; addr_s = c.addr_s; addr_b = c.addr_b;
    buffer_flag = c.buffer_flag; tilingtype = c.tilingtype; stride = c.stride;
    pad = c.pad; xpe_mode = c.xpe_mode; mode = c.mode; last_part = c.last_part;
    kernel = c.kernel; w_q = c.w_q; i_q = c.i_q; o_q = c.o_q; in_x = c.in_x;
    in_y = c.in_y; in_piece = c.in_piece; part_num = c.part_num;
    avg_coe = c.avg_coe; out_x = c.out_x; out_y = c.out_y;
    out_piece = c.out_piece; jump = c.jump; store = c.store;
  endtask

  // Offers one config in IDLE and returns in the cycle after the accept edge.
  task automatic applyStimulus(input cfg_t c, input logic [2:0] m);
    @(negedge clk);
    driveFields(c);
    cfg_mask = m;
    cfg_valid = 1'b1;
    checkOutput("cfg_ready_idle", 128'(cfg_ready), 128'(1'b1));
    for (int k = 0; k < 3; k++)
      if (m[k]) sb.push_back(expWord(k, c));
    @(negedge clk);
    cfg_valid = 1'b0;
    checkOutput("first_valid_latency", 128'(inst_valid), 128'(m != 3'b000));
  endtask

  task automatic waitDone(input string tag, input int expCycles);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_cycles"}, 128'(n), 128'(expCycles));
    @(negedge clk);
    checkOutput({tag, "_done_pulse_width"}, 128'(done), 128'(1'b0));
    checkOutput({tag, "_ready_after_fin"}, 128'(cfg_ready), 128'(1'b1));
  endtask

  // Scoreboard monitor: every accepted word must match the oldest queued one.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && inst_valid && inst_ready) begin
      checkOutput("sb_word_expected", 128'(sb.size() != 0), 128'(1'b1));
      if (sb.size() != 0) checkOutput("sb_word", inst_out, sb.pop_front());
    end
  end

  initial begin
    cfg_t c1, c2, c3, c4, cAlt, c6;

    #12;
    checkOutput("reset_cfg_ready", 128'(cfg_ready), 128'(1'b1));
    checkOutput("reset_inst_valid", 128'(inst_valid), 128'(1'b0));
    checkOutput("reset_inst_out", inst_out, 128'(0));
    checkOutput("reset_done", 128'(done), 128'(1'b0));
    checkOutput("reset_inst_cnt", 128'(inst_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    c1 = randCfg();
    c1.addr_d = 12'h123; c1.mode = 4'h5; c1.in_x = 8'h20; c1.avg_coe = 8'h7F;
    c1.addr_w = 12'hABC; c1.addr_b = 8'h3C; c1.kernel = 4'd3;
    c1.addr_s = 12'h456; c1.out_x = 8'h10; c1.xpe_mode = 2'd2;
    applyStimulus(c1, 3'b111);
    checkOutput("iob_opcode", 128'(inst_out[127:123]), 128'(5'b01010));
    checkOutput("iob_addr_d", 128'(inst_out[121:110]), 128'(12'h123));
    checkOutput("iob_avg_coe", 128'(inst_out[57:50]), 128'(8'h7F));
    @(negedge clk);
    checkOutput("wb_addr_b", 128'(inst_out[109:98]), 128'(12'h03C));
    checkOutput("wb_kernel", 128'(inst_out[97:94]), 128'(4'd3));
    @(negedge clk);
    checkOutput("nio_out_x", 128'(inst_out[109:102]), 128'(8'h10));
    checkOutput("nio_xpe_mode", 128'(inst_out[53:52]), 128'(2'd2));
    waitDone("all3", 1);
    checkOutput("cnt_after_all3", 128'(inst_cnt), 128'(3));

    c2 = randCfg();
    applyStimulus(c2, 3'b101);
    waitDone("mask101", 2);
    checkOutput("cnt_after_101", 128'(inst_cnt), 128'(5));

    c3 = randCfg();
    applyStimulus(c3, 3'b111);
    @(negedge clk);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 128'(inst_valid), 128'(1'b1));
      checkOutput("stall_word", inst_out, expWord(1, c3));
      @(negedge clk);
    end
    inst_ready = 1'b1;
    checkOutput("stall_release_word", inst_out, expWord(1, c3));
    @(negedge clk);
    checkOutput("after_stall_nio", inst_out, expWord(2, c3));
    waitDone("stall", 1);
    checkOutput("cnt_after_stall", 128'(inst_cnt), 128'(8));

    c4 = randCfg();
    applyStimulus(c4, 3'b111);
    cAlt = randCfg();
    driveFields(cAlt);
    cfg_mask = 3'b010;
    cfg_valid = 1'b1;
    begin
      int n = 0;
      while (!done && n < 20) begin
        checkOutput("busy_cfg_ready", 128'(cfg_ready), 128'(1'b0));
        @(negedge clk);
        n++;
      end
      checkOutput("busy_done_cycles", 128'(n), 128'(3));
    end
    checkOutput("fin_cfg_ready", 128'(cfg_ready), 128'(1'b0));
    cfg_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_back_idle", 128'(cfg_ready), 128'(1'b1));
    checkOutput("cnt_after_busy", 128'(inst_cnt), 128'(11));

    applyStimulus(randCfg(), 3'b000);
    checkOutput("mask0_done", 128'(done), 128'(1'b1));
    waitDone("mask0", 0);
    checkOutput("cnt_after_mask0", 128'(inst_cnt), 128'(11));

    applyStimulus(randCfg(), 3'b111);
    @(negedge clk);
    @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_inst_valid", 128'(inst_valid), 128'(1'b0));
    checkOutput("abort_inst_out", inst_out, 128'(0));
    checkOutput("abort_inst_cnt", 128'(inst_cnt), 128'(0));
    checkOutput("abort_cfg_ready", 128'(cfg_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;

    c6 = randCfg();
    applyStimulus(c6, 3'b111);
    waitDone("fresh", 3);
    checkOutput("cnt_after_fresh", 128'(inst_cnt), 128'(3));

    @(negedge clk);
    checkOutput("sb_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npu_inst_encoder.md
# npu_inst_encoder

Packs one layer's NPU configuration into up to three 128-bit instruction words (IOB2N, WB2N, N2IOB) and issues them in that order over a valid/ready stream to the NPU instruction decoder. It sits between the host-side layer scheduler and the per-core decoder. It is the transmitter end of the decoder's instruction format: every field lands in exactly the bit positions the decoder extracts.

## Interface
- OPC_IOB2N, 5'b01010, opcode for the IO-buffer-to-NPU word
- OPC_WB2N, 5'b01011, opcode for the weight-buffer-to-NPU word
- OPC_N2IOB, 5'b01101, opcode for the NPU-to-IO-buffer word
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  encoder idle and able to accept
- cfg_mask  in  3  issue enable: bit0 IOB2N, bit1 WB2N, bit2 N2IOB
- Field inputs, all captured on accept:
  - cfg_addr_d, cfg_addr_w, cfg_addr_s  in  12 each
  - cfg_addr_b  in  8
  - cfg_buffer_flag, cfg_tilingtype, cfg_stride, cfg_pad, cfg_xpe_mode  in  2 each
  - cfg_mode, cfg_last_part, cfg_kernel, cfg_w_q, cfg_i_q, cfg_o_q  in  4 each
  - cfg_in_x, cfg_in_y, cfg_in_piece, cfg_part_num, cfg_avg_coe  in  8 each
  - cfg_out_x, cfg_out_y, cfg_out_piece, cfg_jump, cfg_store  in  8 each
- inst_out  out  128  instruction word
- inst_valid  out  1  inst_out valid
- inst_ready  in  1  downstream accepts
- done  out  1  one-cycle pulse after the last enabled word transfers
- inst_cnt  out  16  total words transferred since reset, wraps

## Operation
- FSM states: IDLE, IOB, WB, NIO, FIN.
- IDLE: cfg_ready=1. On cfg_valid, capture all fields and the mask. Go to the first state whose mask bit is set, in the order IOB, WB, NIO. If the mask is 0, go to FIN.
- IOB/WB/NIO: inst_valid=1 and inst_out holds that state's word. On inst_valid&&inst_ready, go to the next enabled state; if none remains, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Word layouts (bit 122 and every unlisted bit are 0):
  - IOB2N: [127:123]=OPC_IOB2N, [121:110]=addr_d, [109:108]=buffer_flag, [107:104]=mode, [103:96]=in_x, [95:88]=in_y, [87:80]=in_piece, [79:78]=tilingtype, [77:70]=part_num, [69:66]=last_part, [57:50]=avg_coe.
  - WB2N: [127:123]=OPC_WB2N, [121:110]=addr_w, [109:98]={4'b0,addr_b}, [97:94]=kernel, [93:92]=stride, [91:90]=pad, [89:86]=w_q, [85:82]=i_q, [81:78]=o_q.
  - N2IOB: [127:123]=OPC_N2IOB, [121:110]=addr_s, [109:102]=out_x, [101:94]=out_y, [93:86]=out_piece, [85:78]=jump, [77:70]=store, [53:52]=xpe_mode.
- inst_cnt increments by 1 per transfer and wraps from 0xFFFF to 0.
- Captured fields are not affected by input changes while busy.

## Timing
- Reset values: state IDLE, cfg_ready=1, inst_valid=0, inst_out=0, done=0, inst_cnt=0, all capture registers 0. Asserting rst mid-sequence aborts immediately; no partial word survives.
- inst_valid, inst_out and done are registered.
- Config accepted at edge N: first inst_valid is high in cycle N+1.
- With inst_ready held high, words appear in consecutive cycles. done is high in the cycle after the last transfer. cfg_ready is high again the following cycle, so each configuration takes k+2 cycles per accept for k enabled words.
- While inst_valid=1 and inst_ready=0, inst_out and inst_valid hold stable; inst_valid never drops without a transfer.
- inst_out returns to 0 whenever inst_valid=0.
- cfg_ready is low from the cycle after accept through FIN. cfg_valid during that time is ignored and does not stall.
- Mask 0: accept at N, done at N+1, no words, inst_cnt unchanged.

## Test plan
- Reset, then mask=3'b111 with addr_d=0x123, mode=4'h5, in_x=0x20, avg_coe=0x7F, addr_w=0xABC, addr_b=0x3C, kernel=3, addr_s=0x456, out_x=0x10, xpe_mode=2, inst_ready=1 -> three consecutive words:
  - IOB2N: [127:123]=01010, [121:110]=0x123, [107:104]=5, [103:96]=0x20, [57:50]=0x7F.
  - WB2N: [121:110]=0xABC, [109:98]=0x03C, [97:94]=3.
  - N2IOB: [121:110]=0x456, [109:102]=0x10, [53:52]=2.
  - Then done pulse, inst_cnt=3.
- mask=3'b101 -> only IOB2N then N2IOB; WB2N never appears; inst_cnt +2.
- inst_ready low for 5 cycles on the WB2N word -> inst_out is bit-identical and inst_valid stays 1 across those cycles; the transfer occurs on the first ready cycle.
- Change all cfg_* inputs and pulse cfg_valid while busy -> emitted words still carry the originally captured values; cfg_ready=0 throughout.
- mask=0 -> done one cycle after accept, inst_valid never asserts, inst_cnt unchanged.
- Assert rst while the N2IOB word is stalled, then release -> inst_valid=0, inst_out=0, inst_cnt=0, cfg_ready=1; a fresh config then issues normally.
